branch_predict_unit: RTL



---
 rtl/branch_predict_unit_pkg.sv | 31 +++
 rtl/branch_predict_unit_if.sv | 33 +++
 rtl/branch_predict_unit_btb_array.sv | 36 +++
 rtl/branch_predict_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the branch resolution unit: funct3 encodings, BTB entry layout, counter helpers.
package branch_predict_unit_pkg;

  // BTB entry fields are sized for the RV32 core.
  localparam int ENTRY_W = 32;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_instr;

  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;

  typedef struct packed {
    logic               valid;
    logic [ENTRY_W-1:0] tag;
    logic [ENTRY_W-1:0] target;
    logic [1:0]         ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch lookup and execute resolve bus between the pipeline and the branch unit.
interface branch_predict_unit_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            br_valid;
  logic [XLEN-1:0] br_pc;
  logic [2:0]      br_funct3;
  logic [XLEN-1:0] br_imm;
  logic [XLEN-1:0] br_rv1;
  logic [XLEN-1:0] br_rv2;
  logic            br_pred_taken;
  logic [XLEN-1:0] br_pred_target;
  logic            res_valid;
  logic            res_taken;
  logic [XLEN-1:0] res_next_pc;
  logic            res_mispredict;
  logic            res_illegal;

  modport master (
    output fetch_pc, br_valid, br_pc, br_funct3, br_imm, br_rv1, br_rv2,
           br_pred_taken, br_pred_target,
    input  pred_taken, pred_target, res_valid, res_taken, res_next_pc,
           res_mispredict, res_illegal
  );

  modport slave (
    input  fetch_pc, br_valid, br_pc, br_funct3, br_imm, br_rv1, br_rv2,
           br_pred_taken, br_pred_target,
    output pred_taken, pred_target, res_valid, res_taken, res_next_pc,
           res_mispredict, res_illegal
  );
endinterface

// File: rtl/branch_predict_unit_btb_array.sv
// Direct-mapped BTB storage: fetch and resolve read ports (combinational), one synchronous write port.
module btb_array
  import branch_predict_unit_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_a,
  output btb_entry_t       rd_entry_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output btb_entry_t       rd_entry_b,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  btb_entry_t mem [ENTRIES];

  assign rd_entry_a = mem[rd_idx_a];
  assign rd_entry_b = mem[rd_idx_b];

  // Only valid and ctr are cleared; tag/target are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i].valid <= 1'b0;
        mem[i].ctr   <= CTR_WNT;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution + BTB/2-bit predictor: combinational fetch prediction, 1-cycle registered resolve.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter bit PRED_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predict_unit_if.slave  bus,
  output logic [31:0]           cnt_branches,
  output logic [31:0]           cnt_mispredicts
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  logic [IDX_W-1:0] f_idx, r_idx;
  logic [XLEN-1:0]  f_tag, r_tag;
  btb_entry_t       f_ent, r_ent, w_ent;
  logic             f_hit, r_hit, wr_en;

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign r_idx = bus.br_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc >> (IDX_W + 2);
  assign r_tag = bus.br_pc >> (IDX_W + 2);

  btb_array #(.ENTRIES(BTB_ENTRIES), .IDX_W(IDX_W)) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_a   (f_idx),
    .rd_entry_a (f_ent),
    .rd_idx_b   (r_idx),
    .rd_entry_b (r_ent),
    .wr_en      (wr_en),
    .wr_idx     (r_idx),
    .wr_entry   (w_ent)
  );

  assign f_hit           = f_ent.valid && (f_ent.tag == f_tag);
  assign r_hit           = r_ent.valid && (r_ent.tag == r_tag);
  assign bus.pred_taken  = PRED_EN && f_hit && f_ent.ctr[1];
  assign bus.pred_target = bus.pred_taken ? f_ent.target : bus.fetch_pc + XLEN'(4);

  logic            taken, illegal, mispredict, eq, lt, ltu;
  logic [XLEN-1:0] fall, tgt, next_pc;

  always_comb begin
    eq      = bus.br_rv1 == bus.br_rv2;
    lt      = $signed(bus.br_rv1) < $signed(bus.br_rv2);
    ltu     = bus.br_rv1 < bus.br_rv2;
    taken   = 1'b0;
    illegal = 1'b0;
    case (branch_instr'(bus.br_funct3))
      BEQ:     taken = eq;
      BNE:     taken = !eq;
      BLT:     taken = lt;
      BGE:     taken = !lt;
      BLTU:    taken = ltu;
      BGEU:    taken = !ltu;
      default: illegal = 1'b1;
    endcase
    fall       = bus.br_pc + XLEN'(4);
    tgt        = bus.br_pc + bus.br_imm;
    next_pc    = taken ? tgt : fall;
    mispredict = illegal ? (bus.br_pred_target != fall)
                         : ((taken != bus.br_pred_taken) || (next_pc != bus.br_pred_target));
  end

  // Not-taken misses leave the BTB alone; a reset cycle is blocked inside btb_array.
  assign wr_en        = PRED_EN && bus.br_valid && !illegal && (taken || r_hit);
  assign w_ent.valid  = 1'b1;
  assign w_ent.tag    = r_tag;
  assign w_ent.target = taken ? tgt : r_ent.target;
  assign w_ent.ctr    = r_hit ? ctr_step(r_ent.ctr, taken) : CTR_WT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.res_valid      <= 1'b0;
      bus.res_taken      <= 1'b0;
      bus.res_next_pc    <= '0;
      bus.res_mispredict <= 1'b0;
      bus.res_illegal    <= 1'b0;
      cnt_branches       <= '0;
      cnt_mispredicts    <= '0;
    end else begin
      bus.res_valid <= bus.br_valid;
      if (bus.br_valid) begin
        bus.res_taken      <= taken;
        bus.res_next_pc    <= next_pc;
        bus.res_mispredict <= mispredict;
        bus.res_illegal    <= illegal;
        if (!illegal) begin
          if (cnt_branches != '1) cnt_branches <= cnt_branches + 32'd1;
          if (mispredict && cnt_mispredicts != '1) cnt_mispredicts <= cnt_mispredicts + 32'd1;
        end
      end
    end
  end

endmodule
